alpha_fetch_queue: RTL

- Instruction fetch stage directly upstream of the Ebox decode stage.
- Owns the fetch PC and drives one address per cycle to both the Icache and the Metal instruction memory.
- Selects Metal memory when the PC is in the Metal range.
- Buffers fetched {pc, inst} pairs in a small FIFO and presents them to the Ebox over a valid/ready handshake.
- Flushes and restarts on redirect (branch or exception).

---
 rtl/alpha_fetch_pkg.sv | 21 ++
 rtl/alpha_fetch_fifo.sv | 92 +++++++++
 rtl/alpha_fetch_queue.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alpha_fetch_pkg.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// alpha_fetch_pkg
// Shared definitions for the instruction fetch queue: address/instruction
// widths, the default base of the Metal address range and the {pc, inst}
// entry type carried from fetch to the Ebox.
// ----------------------------------------------------------------------------
package alpha_fetch_pkg;

    localparam int ADDR_W = 64;
    localparam int INST_W = 32;

    // Lowest address served by Metal instruction memory instead of the Icache.
    localparam logic [ADDR_W-1:0] METAL_BASE_DEFAULT = 64'hffff_ffff_ffff_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/alpha_fetch_fifo.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// alpha_fetch_fifo
// Small circular FIFO of fetch entries with a synchronous flush.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write wr_entry at the tail (ignored when full and not popping)
//   pop         retire the head entry (ignored when empty)
//   flush       empty the FIFO; wins over push and pop in the same cycle
//   wr_entry    entry to write on push
//   head        entry at the head (contents undefined when empty)
//   full/empty  status flags
//   count       number of valid entries, 0..DEPTH
// ----------------------------------------------------------------------------
module alpha_fetch_fifo
    import alpha_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wr_entry,
    output fetch_entry_t               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on natural overflow.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; entries are only observed through count, which is reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: rtl/alpha_fetch_queue.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// alpha_fetch_queue
// Instruction fetch stage feeding the Ebox. Owns the fetch PC, issues one
// read per cycle to the Icache or to Metal memory (PC >= METAL_BASE), queues
// {pc, inst} pairs and hands them to the Ebox over valid/ready. A redirect
// flushes the queue and restarts fetch at a word-aligned target.
//
// Optional build macro ALPHA_FETCH_BYPASS_EN: on an empty queue the word being
// fetched is presented to the Ebox in the same cycle, and skips the FIFO when
// the Ebox accepts it.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   fetch_addr                 current fetch PC to Icache and Metal memory
//   icache_rd_en, metal_rd_en  read enables for the two instruction sources
//   icache_data, metal_data    instruction words returned by the sources
//   icache_stall, metal_stall  source cannot deliver this cycle
//   redirect, redirect_pc      flush and restart fetch at redirect_pc
//   inst, inst_pc, inst_valid  head instruction presented to the Ebox
//   inst_ready                 Ebox accepts the head this cycle
//   occupancy                  number of queued entries
// ----------------------------------------------------------------------------
module alpha_fetch_queue
    import alpha_fetch_pkg::*;
#(
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = 64'h0,
    parameter logic [ADDR_W-1:0] METAL_BASE = METAL_BASE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [63:0]             fetch_addr,
    output logic                    icache_rd_en,
    output logic                    metal_rd_en,
    input  logic [31:0]             icache_data,
    input  logic [31:0]             metal_data,
    input  logic                    icache_stall,
    input  logic                    metal_stall,
    input  logic                    redirect,
    input  logic [63:0]             redirect_pc,
    output logic [31:0]             inst,
    output logic [63:0]             inst_pc,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [$clog2(DEPTH):0]  occupancy
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    fetch_entry_t       last_q, last_d;
    fetch_entry_t       fifo_head, fetch_entry, out_entry;
    logic               fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic               metal_sel, stall_sel, fetch_req, push, byp_valid;

    assign metal_sel   = (pc_q >= METAL_BASE);
    assign stall_sel   = metal_sel ? metal_stall : icache_stall;
    assign fetch_entry = '{pc: pc_q, inst: (metal_sel ? metal_data : icache_data)};

    // Only a real queued head can be popped; a bypassed word never enters the FIFO.
    assign fifo_pop    = ~fifo_empty & inst_ready;
    assign fetch_req   = ~fifo_full | fifo_pop;
    assign push        = fetch_req & ~stall_sel & ~redirect;

`ifdef ALPHA_FETCH_BYPASS_EN
    assign byp_valid   = fifo_empty & push;
    assign fifo_push   = push & ~(byp_valid & inst_ready);
`else
    assign byp_valid   = 1'b0;
    assign fifo_push   = push;
`endif

    assign fetch_addr   = pc_q;
    assign icache_rd_en = fetch_req & ~metal_sel;
    assign metal_rd_en  = fetch_req &  metal_sel;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = {redirect_pc[63:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + 64'd4;
        end
    end

    // The Ebox sees the last presented entry while nothing is valid, so the
    // undefined contents of an empty FIFO slot never reach the outputs.
    always_comb begin
        inst_valid = ~fifo_empty | byp_valid;
        out_entry  = last_q;
        if (byp_valid) begin
            out_entry = fetch_entry;
        end else if (!fifo_empty) begin
            out_entry = fifo_head;
        end
        last_d     = out_entry;
    end

    assign inst    = out_entry.inst;
    assign inst_pc = out_entry.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            last_q <= '0;
        end else begin
            pc_q   <= pc_d;
            last_q <= last_d;
        end
    end

    // Redirect drives flush, which discards any same-cycle pop inside the FIFO.
    alpha_fetch_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .flush    (redirect),
        .wr_entry (fetch_entry),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (occupancy)
    );

endmodule
